// File: rtl/m1_gpi_port.sv
// m1_gpi_port: memory-mapped general-purpose input port with edge-triggered sticky interrupts.
// Define M1_GPI_DEBOUNCE_EN to insert a prescaled 3-sample debounce filter after the synchronizer.
module m1_gpi_port #(
  parameter int WIDTH        = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_DIV = 1000
) (
  input  logic             clk,
  input  logic             async_rst,
  input  logic [WIDTH-1:0] gpi,
  input  logic [1:0]       addr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             rd_valid,
  output logic             irq
);
  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_RISE = 2'd1;
  localparam logic [1:0] A_FALL = 2'd2;
  localparam logic [1:0] A_PEND = 2'd3;

  logic [WIDTH*SYNC_STAGES-1:0] r_sync;
  logic [WIDTH-1:0]             w_sync;
  logic [WIDTH-1:0]             r_deb;
  logic [WIDTH-1:0]             r_deb_q;
  logic [WIDTH-1:0]             r_rise_en;
  logic [WIDTH-1:0]             r_fall_en;
  logic [WIDTH-1:0]             r_pending;
  logic [WIDTH-1:0]             r_rdata;
  logic                         r_rd_valid;
  logic                         r_irq;
  logic [WIDTH-1:0]             w_rise;
  logic [WIDTH-1:0]             w_fall;
  logic [WIDTH-1:0]             w_clr;
  logic [WIDTH-1:0]             w_pending_next;
  logic [WIDTH-1:0]             w_rd_mux;

  // Stage 0 sits in the low slice; the chain output is the top slice.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[WIDTH*(SYNC_STAGES-1)-1:0], gpi};
    end
  end

  assign w_sync = r_sync[WIDTH*SYNC_STAGES-1 -: WIDTH];

`ifdef M1_GPI_DEBOUNCE_EN
  localparam int PW = (DEBOUNCE_DIV > 2) ? $clog2(DEBOUNCE_DIV) : 1;

  logic [PW-1:0]    r_presc;
  logic             w_tick;
  logic [WIDTH-1:0] r_hist0;
  logic [WIDTH-1:0] r_hist1;
  logic [WIDTH-1:0] r_hist2;

  assign w_tick = (r_presc == PW'(DEBOUNCE_DIV - 1));

  // A bit follows the history only when all three samples agree; otherwise it holds.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_presc <= '0;
      r_hist0 <= '0;
      r_hist1 <= '0;
      r_hist2 <= '0;
      r_deb   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        r_hist0 <= w_sync;
        r_hist1 <= r_hist0;
        r_hist2 <= r_hist1;
      end
      r_deb <= (r_hist0 & r_hist1 & r_hist2) |
               (r_deb & (r_hist0 | r_hist1 | r_hist2));
    end
  end
`else
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_deb <= '0;
    end else begin
      r_deb <= w_sync;
    end
  end
`endif

  always_comb begin
    w_rise         = r_deb & ~r_deb_q;
    w_fall         = ~r_deb & r_deb_q;
    w_clr          = (wr_en && (addr == A_PEND)) ? wdata : '0;
    // Set terms are OR-ed after the clear so a same-cycle edge wins.
    w_pending_next = (r_pending & ~w_clr) | (w_rise & r_rise_en) | (w_fall & r_fall_en);
    w_rd_mux       = '0;
    case (addr)
      A_DATA:  w_rd_mux = r_deb;
      A_RISE:  w_rd_mux = r_rise_en;
      A_FALL:  w_rd_mux = r_fall_en;
      default: w_rd_mux = r_pending;
    endcase
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_deb_q    <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_pending  <= '0;
      r_irq      <= 1'b0;
      r_rdata    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_deb_q    <= r_deb;
      r_pending  <= w_pending_next;
      r_irq      <= |w_pending_next;
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rdata <= w_rd_mux;
      end
      if (wr_en && (addr == A_RISE)) begin
        r_rise_en <= wdata;
      end
      if (wr_en && (addr == A_FALL)) begin
        r_fall_en <= wdata;
      end
    end
  end

  assign rdata    = r_rdata;
  assign rd_valid = r_rd_valid;
  assign irq      = r_irq;

endmodule

// File: tb/tb_m1_gpi_port.sv
// Self-checking bench for m1_gpi_port: register table, edge/pending sequences, debounce and async reset.
module tb_m1_gpi_port;
  localparam int W = 16;
`ifdef M1_GPI_DEBOUNCE_EN
  localparam int SETTLE = 24;
`else
  localparam int SETTLE = 5;
`endif

  logic         clk = 1'b0;
  logic         async_rst = 1'b1;
  logic [W-1:0] gpi = '0;
  logic [1:0]   addr = '0;
  logic         wr_en = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         rd_en = 1'b0;
  logic [W-1:0] rdata;
  logic         rd_valid;
  logic         irq;

  m1_gpi_port #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_DIV(4)) dut (
    .clk(clk), .async_rst(async_rst), .gpi(gpi), .addr(addr), .wr_en(wr_en),
    .wdata(wdata), .rd_en(rd_en), .rdata(rdata), .rd_valid(rd_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic         rd;
    logic [1:0]   a;
    logic [W-1:0] wd;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         vecs[16];
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h, required 0x%04h", nm, act, exp);
    end
  endtask

  task automatic check_bit(input string nm, input logic act, input logic exp);
    check(nm, {{(W-1){1'b0}}, act}, {{(W-1){1'b0}}, exp});
  endtask

  // One clock; any read result produced at this edge is popped and scored.
  task automatic step();
    string        nm;
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rd_valid: rdata 0x%04h, required no read outstanding", rdata);
      end else begin
        nm = name_q.pop_front();
        e  = exp_q.pop_front();
        $display("read %s: rdata=0x%04h expect=0x%04h", nm, rdata, e);
        check(nm, rdata, e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic bus(input logic wr, input logic rd, input logic [1:0] a,
                     input logic [W-1:0] wd, input logic [W-1:0] exp, input string nm);
    addr  = a;
    wr_en = wr;
    rd_en = rd;
    wdata = wd;
    if (rd) begin
      exp_q.push_back(exp);
      name_q.push_back(nm);
    end
    if (wr) $display("write addr=%0d wdata=0x%04h", a, wd);
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 2'd0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 2'd1, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 2'd2, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 2'd3, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 2'd1, 16'hA5A5, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 2'd1, 16'h0000, 16'hA5A5};
    vecs[6]  = '{1'b1, 1'b0, 2'd2, 16'h5A5A, 16'h0000};
    vecs[7]  = '{1'b0, 1'b1, 2'd2, 16'h0000, 16'h5A5A};
    vecs[8]  = '{1'b1, 1'b1, 2'd1, 16'h1234, 16'hA5A5};
    vecs[9]  = '{1'b0, 1'b1, 2'd1, 16'h0000, 16'h1234};
    vecs[10] = '{1'b1, 1'b0, 2'd0, 16'hFFFF, 16'h0000};
    vecs[11] = '{1'b0, 1'b1, 2'd0, 16'h0000, 16'h0000};
    vecs[12] = '{1'b1, 1'b0, 2'd1, 16'h0001, 16'h0000};
    vecs[13] = '{1'b1, 1'b0, 2'd2, 16'h0000, 16'h0000};
    vecs[14] = '{1'b0, 1'b1, 2'd1, 16'h0000, 16'h0001};
    vecs[15] = '{1'b0, 1'b1, 2'd2, 16'h0000, 16'h0000};

    idle(3);
    check_bit("reset_irq", irq, 1'b0);
    check_bit("reset_rd_valid", rd_valid, 1'b0);
    check("reset_rdata", rdata, '0);
    async_rst = 1'b0;
    idle(2);

    for (int i = 0; i < 16; i++) begin
      bus(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].wd, vecs[i].exp, $sformatf("vec%0d", i));
    end
    check_bit("table_irq", irq, 1'b0);

`ifndef M1_GPI_DEBOUNCE_EN
    // Rise on bit 0 with RISE_EN=1: DATA after 3 edges, pending and irq after 4.
    gpi = 16'h0001;
    idle(3);
    check_bit("irq_before_latch", irq, 1'b0);
    bus(1'b0, 1'b1, 2'd0, '0, 16'h0001, "rise_data");
    check_bit("irq_after_rise", irq, 1'b1);
    bus(1'b0, 1'b1, 2'd3, '0, 16'h0001, "rise_pending");
    idle(1);
    check_bit("rd_valid_pulse", rd_valid, 1'b0);
    check("rdata_hold", rdata, 16'h0001);

    // Clear collides with a fresh rise on the same bit.
    gpi = 16'h0000;
    idle(4);
    gpi = 16'h0001;
    idle(3);
    bus(1'b1, 1'b0, 2'd3, 16'h0001, '0, "clr_vs_rise");
    bus(1'b0, 1'b1, 2'd3, '0, 16'h0001, "set_wins");
    check_bit("irq_set_wins", irq, 1'b1);
    bus(1'b1, 1'b0, 2'd3, 16'h0001, '0, "clr_plain");
    check_bit("irq_after_clr", irq, 1'b0);
    bus(1'b0, 1'b1, 2'd3, '0, 16'h0000, "pending_cleared");
`endif

    // Falling-edge enable on bit 15 only.
    bus(1'b1, 1'b0, 2'd1, 16'h0000, '0, "rise_en_off");
    bus(1'b1, 1'b0, 2'd2, 16'h8000, '0, "fall_en_msb");
    bus(1'b1, 1'b0, 2'd3, 16'hFFFF, '0, "clr_all");
    gpi = 16'hFFFF;
    idle(SETTLE + 2);
    bus(1'b0, 1'b1, 2'd3, '0, 16'h0000, "rise_ignored");
    gpi = 16'h7FFF;
    idle(SETTLE + 2);
    bus(1'b0, 1'b1, 2'd0, '0, 16'h7FFF, "fall_data");
    bus(1'b0, 1'b1, 2'd3, '0, 16'h8000, "fall_pending");
    check_bit("irq_fall", irq, 1'b1);
    gpi = 16'hFFFF;
    idle(SETTLE + 2);
    bus(1'b0, 1'b1, 2'd3, '0, 16'h8000, "rise_back_no_change");
    bus(1'b1, 1'b0, 2'd1, 16'hFFFF, '0, "rise_en_all");
    bus(1'b1, 1'b0, 2'd2, 16'h0000, '0, "fall_en_off");
    bus(1'b0, 1'b1, 2'd3, '0, 16'h8000, "en_change_keeps");
    bus(1'b1, 1'b0, 2'd1, 16'h0000, '0, "rise_en_off2");
    bus(1'b1, 1'b0, 2'd3, 16'hFFFF, '0, "clr_all2");
    check_bit("irq_clr_all", irq, 1'b0);

`ifdef M1_GPI_DEBOUNCE_EN
    // 5-cycle pulse spans at most two prescaler ticks and must be rejected.
    gpi = 16'h0000;
    idle(SETTLE + 2);
    bus(1'b1, 1'b0, 2'd1, 16'h0008, '0, "rise_en_b3");
    bus(1'b1, 1'b0, 2'd3, 16'hFFFF, '0, "clr_deb");
    gpi = 16'h0008;
    idle(5);
    gpi = 16'h0000;
    idle(20);
    bus(1'b0, 1'b1, 2'd0, '0, 16'h0000, "glitch_data");
    bus(1'b0, 1'b1, 2'd3, '0, 16'h0000, "glitch_pending");
    gpi = 16'h0008;
    idle(20);
    bus(1'b0, 1'b1, 2'd0, '0, 16'h0008, "held_data");
    bus(1'b0, 1'b1, 2'd3, '0, 16'h0008, "held_pending");
    gpi = 16'hFFFF;
    idle(SETTLE + 2);
    bus(1'b1, 1'b0, 2'd1, 16'h0000, '0, "rise_en_off3");
`endif

    // Build PENDING=0x00FF from falls on the low byte, then reset mid-cycle.
    bus(1'b1, 1'b0, 2'd2, 16'h00FF, '0, "fall_en_low");
    bus(1'b1, 1'b0, 2'd3, 16'hFFFF, '0, "clr_pre");
    gpi = 16'hFF00;
    idle(SETTLE + 2);
    bus(1'b0, 1'b1, 2'd3, '0, 16'h00FF, "pend_pre_reset");
    check_bit("irq_pre_reset", irq, 1'b1);
    #3;
    async_rst = 1'b1;
    gpi = 16'h0008;
    #1;
    check_bit("async_irq", irq, 1'b0);
    check_bit("async_rd_valid", rd_valid, 1'b0);
    check("async_rdata", rdata, '0);
    idle(2);
    async_rst = 1'b0;
    bus(1'b0, 1'b1, 2'd0, '0, 16'h0000, "post_rst_data");
    bus(1'b0, 1'b1, 2'd3, '0, 16'h0000, "post_rst_pending");
    bus(1'b0, 1'b1, 2'd1, '0, 16'h0000, "post_rst_rise_en");
    bus(1'b0, 1'b1, 2'd2, '0, 16'h0000, "post_rst_fall_en");
    idle(SETTLE + 2);
    bus(1'b0, 1'b1, 2'd0, '0, 16'h0008, "requalify_data");
    check_bit("requalify_irq", irq, 1'b0);

    idle(2);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_reads: %0d outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/m1_gpi_port.md
Name: m1_gpi_port

Overview:
Memory-mapped general-purpose input port for the M1T core; the read-side counterpart of the core's gpo output register. It synchronizes the external gpi pins into the clk domain and optionally debounces them. It detects rising and falling edges, latches them into sticky pending bits and raises an interrupt. The core reads and clears the port through a simple single-cycle register bus.

Parameters:
WIDTH, 16, number of input pins (1..32).
SYNC_STAGES, 2, flip-flops in the input synchronizer chain (>=2).
DEBOUNCE_DIV, 1000, clk cycles between debounce sample ticks (>=2; only used with M1_GPI_DEBOUNCE_EN).

Ports:
clk  in  1  system clock, rising edge.
async_rst  in  1  asynchronous reset, active-high.
gpi  in  WIDTH  raw external inputs, asynchronous to clk.
addr  in  2  register select: 0 DATA, 1 RISE_EN, 2 FALL_EN, 3 PENDING.
wr_en  in  1  register write strobe.
wdata  in  WIDTH  write data.
rd_en  in  1  register read strobe.
rdata  out  WIDTH  read data, registered.
rd_valid  out  1  high for one cycle when rdata is valid.
irq  out  1  interrupt, level, registered.

Behaviour:
- Reset (async assert, release synchronous to clk) clears all of the following to 0: synchronizer chain, debounce state, prescaler, DATA, RISE_EN, FALL_EN, PENDING, rdata, rd_valid, irq.
- Synchronizer: SYNC_STAGES-deep flop chain per bit; the output of the chain is `sync`.
- Debounced value `deb` (DATA register):
  - Without debounce, `deb` = `sync`, registered.
  - Total pin-to-DATA latency is SYNC_STAGES+1 cycles.
- Edge detect: keep `deb_q` as `deb` delayed one cycle.
  - rise = deb & ~deb_q.
  - fall = ~deb & deb_q.
- PENDING update, every cycle: PENDING <= (PENDING & ~clr) | (rise & RISE_EN) | (fall & FALL_EN).
  - clr = wdata when wr_en and addr==3, else 0.
  - Set wins over a simultaneous clear of the same bit.
- irq <= |(PENDING_next); asserts 1 cycle after the edge is latched.
  - Changing RISE_EN or FALL_EN never clears existing pending bits.
- Writes:
  - addr 0 (DATA) is read-only; a write to it is ignored.
  - addr 1 and 2 load wdata into RISE_EN / FALL_EN at the next edge.
  - addr 3 is write-1-to-clear.
- Reads: on rd_en, rdata <= register selected by addr, sampled before any same-cycle write; rd_valid <= 1 for that cycle only.
  - When rd_en=0: rd_valid <= 0 and rdata holds its previous value.
  - Simultaneous rd_en and wr_en to the same address returns the old value.
- Bus has no backpressure: every strobe completes in one cycle. Strobes may occur on every consecutive cycle.
- WIDTH < 32: upper wdata bits are not present; no aliasing.

Optional Feature:
Macro M1_GPI_DEBOUNCE_EN.
- Defined:
  - A prescaler counts 0..DEBOUNCE_DIV-1 and emits a one-cycle tick at the wrap.
  - On each tick, every bit shifts `sync` into a 3-entry history.
  - `deb` bit updates to the history value only when all 3 entries agree; otherwise it holds.
  - A level change is accepted 3 ticks after it reaches `sync`, subject to prescaler phase. Glitches shorter than 2 ticks are rejected.
  - Reset clears the history to 0, so pins high at reset appear after 3 ticks.
- Not defined: no prescaler or history; `deb` follows `sync` with no filtering, as described in Behaviour.

Test Plan:
- Reset then read addr 0,1,2,3 -> rdata 0x0000 each, rd_valid one cycle after each rd_en, irq=0.
- No debounce: RISE_EN=0x0001; gpi 0x0000->0x0001 at cycle T -> DATA reads 0x0001 from T+3; PENDING=0x0001 and irq=1 by T+5.
- Write PENDING 0x0001 in the same cycle as a new rise on bit 0 -> PENDING stays 0x0001 (set wins); a subsequent clear with no edge -> PENDING 0x0000, irq=0 next cycle.
- FALL_EN=0x8000, RISE_EN=0; gpi 0xFFFF->0x7FFF -> PENDING=0x8000; gpi back to 0xFFFF -> PENDING unchanged.
- With M1_GPI_DEBOUNCE_EN, DEBOUNCE_DIV=4: pulse gpi bit 3 high for 5 clks -> DATA stays 0x0000, no pending; hold high for 20 clks -> DATA=0x0008.
- Assert async_rst mid-debounce with pending=0x00FF -> all outputs 0 immediately, and after release DATA re-qualifies from an empty history.
